// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: M/A/Q/Q_1 registers driven by the control
// FSM's strobes, plus a registered 2N-bit product with a one-cycle valid pulse.
module booth_datapath #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   multiplicand_i,
  input  logic [N-1:0]   multiplier_i,
  input  logic           load_b,
  input  logic           load_a,
  input  logic           load_add,
  input  logic           add_sub,
  input  logic           shift_q,
  input  logic           done,
  output logic           q0,
  output logic           q_1,
  output logic [2*N-1:0] product_o,
  output logic           product_valid_o
);

  logic [N-1:0]   m_q, m_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           valid_q, valid_d;

  logic [N:0]     m_ext;
  logic [N:0]     sum;
  logic [N:0]     add_res;
  logic [N:0]     a_shr;
  logic [N-1:0]   q_shr;

  // A is one bit wider than M so that subtracting M = -2^(N-1) never overflows.
  assign m_ext   = {m_q[N-1], m_q};
  assign sum     = add_sub ? (a_q - m_ext) : (a_q + m_ext);
  assign add_res = load_add ? sum : a_q;

  // Arithmetic right shift of {add_res, Q}; the add result feeds the shift so
  // a fused add+shift completes one Booth iteration per cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_a_shr
      assign a_shr[gi] = add_res[gi+1];
    end
    for (gi = 0; gi < N - 1; gi++) begin : g_q_shr
      assign q_shr[gi] = q_q[gi+1];
    end
  endgenerate
  assign a_shr[N]   = add_res[N];
  assign q_shr[N-1] = add_res[0];

  always_comb begin
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    prod_d  = prod_q;
    valid_d = done;

    if (load_b) begin
      m_d = multiplicand_i;
    end

    if (load_a) begin
      a_d  = '0;
      q_d  = multiplier_i;
      q1_d = 1'b0;
    end else if (shift_q) begin
      a_d  = a_shr;
      q_d  = q_shr;
      q1_d = q_q[0];
    end else if (load_add) begin
      a_d  = sum;
    end

    // Captures the pre-edge {A,Q}, so done may overlap the next operand load.
    if (done) begin
      prod_d = {a_q[N-1:0], q_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign q0              = q_q[0];
  assign q_1             = q1_q;
  assign product_o       = prod_q;
  assign product_valid_o = valid_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: directed vectors, multi-cycle corner
// sequences and random operands checked against plain signed multiplication.
module tb_booth_datapath;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   multiplicand_i;
  logic [N-1:0]   multiplier_i;
  logic           load_b;
  logic           load_a;
  logic           load_add;
  logic           add_sub;
  logic           shift_q;
  logic           done;
  logic           q0;
  logic           q_1;
  logic [2*N-1:0] product_o;
  logic           product_valid_o;

  int n_checks = 0;
  int n_pass   = 0;

  booth_datapath #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .load_b         (load_b),
    .load_a         (load_a),
    .load_add       (load_add),
    .add_sub        (add_sub),
    .shift_q        (shift_q),
    .done           (done),
    .q0             (q0),
    .q_1            (q_1),
    .product_o      (product_o),
    .product_valid_o(product_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %04h, expected %04h", name, act, exp);
    else n_pass++;
  endtask

  // One clock: drive strobes, step past the edge, then release all strobes.
  task automatic cyc(input bit la, input bit lb, input bit ld, input bit as,
                     input bit sh, input bit dn);
    load_a = la; load_b = lb; load_add = ld; add_sub = as; shift_q = sh; done = dn;
    @(posedge clk);
    #1;
    load_a = 0; load_b = 0; load_add = 0; add_sub = 0; shift_q = 0; done = 0;
  endtask

  task automatic load_ops(input logic [7:0] m, input logic [7:0] q, input bit ldb);
    multiplicand_i = m;
    multiplier_i   = q;
    cyc(1, ldb, 0, 0, 0, 0);
  endtask

  // Booth control reference: the bit pair seen at iteration i is (mult[i], mult[i-1]).
  task automatic iterate(input logic [7:0] mult, input int steps, input bit allow_split);
    logic prev, cur;
    bit   do_add, sub;
    prev = 1'b0;
    for (int i = 0; i < steps; i++) begin
      cur = mult[i];
      check("q0", {15'd0, q0}, {15'd0, cur});
      check("q_1", {15'd0, q_1}, {15'd0, prev});
      do_add = (cur != prev);
      sub    = cur & ~prev;
      if (do_add && allow_split && ($urandom_range(0, 1) == 1)) begin
        cyc(0, 0, 1, sub, 0, 0);
        cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
      end else if (do_add) begin
        cyc(0, 0, 1, sub, 1, 0);
      end else begin
        cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
      end
      prev = cur;
    end
  endtask

  task automatic finish_mul(input string name, input logic [15:0] exp);
    cyc(0, 0, 0, 0, 0, 1);
    check({name, "_valid"}, {15'd0, product_valid_o}, 16'd1);
    check(name, product_o, exp);
    cyc(0, 0, 0, 0, 0, 0);
    check({name, "_valid_drop"}, {15'd0, product_valid_o}, 16'd0);
    check({name, "_hold"}, product_o, exp);
  endtask

  function automatic logic [15:0] golden(input logic [7:0] m, input logic [7:0] q);
    int mi, qi;
    mi = $signed(m);
    qi = $signed(q);
    return 16'(mi * qi);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rm, rq;

    vecs[0] = '{8'h03, 8'hFE, 16'hFFFA};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h07, 8'h09, 16'h003F};
    vecs[3] = '{8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{8'h80, 8'h7F, 16'hC080};
    vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[7] = '{8'h80, 8'h01, 16'hFF80};

    // Reset with every strobe asserted.
    rst = 0;
    multiplicand_i = 8'hFF; multiplier_i = 8'hFF;
    load_a = 1; load_b = 1; load_add = 1; add_sub = 1; shift_q = 1; done = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", product_o, 16'h0000);
    check("rst_valid", {15'd0, product_valid_o}, 16'd0);
    check("rst_q0", {15'd0, q0}, 16'd0);
    check("rst_q_1", {15'd0, q_1}, 16'd0);
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);
    check("idle_product", product_o, 16'h0000);
    check("idle_valid", {15'd0, product_valid_o}, 16'd0);
    check("idle_q0", {15'd0, q0}, 16'd0);

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      load_ops(vecs[v].m, vecs[v].q, 1);
      iterate(vecs[v].q, N, (v % 2) == 1);
      finish_mul("vec_product", vecs[v].exp);
      $display("vec %0d: %02h x %02h -> %04h", v, vecs[v].m, vecs[v].q, product_o);
    end

    // Single fused subtract-and-shift: A=0, M=5, Q=1.
    load_ops(8'h05, 8'h01, 1);
    cyc(0, 0, 1, 1, 1, 0);
    check("fused_q0", {15'd0, q0}, 16'd0);
    check("fused_q_1", {15'd0, q_1}, 16'd1);
    finish_mul("fused_AQ", 16'hFD80);
    $display("fused step: {A,Q} = %04h", product_o);

    // Separate add then shift: A=0, M=3, Q=0.
    load_ops(8'h03, 8'h00, 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("sep_q_1", {15'd0, q_1}, 16'd0);
    finish_mul("sep_AQ", 16'h0180);
    $display("separate ops: {A,Q} = %04h", product_o);

    // load_a beats a simultaneous fused iteration (A is nonzero beforehand).
    multiplier_i = 8'h5B;
    cyc(1, 0, 1, 1, 1, 0);
    check("prio_q0", {15'd0, q0}, 16'd1);
    check("prio_q_1", {15'd0, q_1}, 16'd0);
    finish_mul("prio_AQ", 16'h005B);
    $display("priority: {A,Q} = %04h", product_o);

    // Back-to-back: done overlaps the next load.
    load_ops(8'h03, 8'hFE, 1);
    iterate(8'hFE, N, 0);
    multiplicand_i = 8'h07; multiplier_i = 8'h09;
    cyc(1, 1, 0, 0, 0, 1);
    check("b2b_valid", {15'd0, product_valid_o}, 16'd1);
    check("b2b_first", product_o, 16'hFFFA);
    iterate(8'h09, N, 0);
    finish_mul("b2b_second", 16'h003F);
    $display("back-to-back: second product %04h", product_o);

    // Reset after the 4th iteration, with strobes still active.
    load_ops(8'h07, 8'h09, 1);
    iterate(8'h09, 4, 0);
    rst = 0;
    load_a = 0; load_b = 0; load_add = 1; add_sub = 1; shift_q = 1; done = 1;
    @(posedge clk);
    #1;
    rst = 1;
    load_add = 0; add_sub = 0; shift_q = 0; done = 0;
    check("midrst_product", product_o, 16'h0000);
    check("midrst_valid", {15'd0, product_valid_o}, 16'd0);
    check("midrst_q0", {15'd0, q0}, 16'd0);
    check("midrst_q_1", {15'd0, q_1}, 16'd0);
    // M must also have cleared: multiply without reloading it.
    load_ops(8'h07, 8'h09, 0);
    iterate(8'h09, N, 0);
    finish_mul("midrst_m_cleared", 16'h0000);
    load_ops(8'h07, 8'h09, 1);
    iterate(8'h09, N, 1);
    finish_mul("after_rst_7x9", 16'h003F);
    $display("after mid reset: 7 x 9 -> %04h", product_o);

    // Random operands against a signed golden product.
    for (int r = 0; r < 200; r++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      load_ops(rm, rq, 1);
      iterate(rq, N, 1);
      finish_mul("rand_product", golden(rm, rq));
      $display("rand %0d: %02h x %02h -> %04h", r, rm, rq, product_o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_datapath.md
# booth_datapath

Radix-2 Booth multiplier datapath. It sits directly downstream of the Booth control FSM: it consumes the FSM's load/add/shift/done strobes and returns the `q0`/`q_1` bit pair the FSM uses to choose the next operation. It holds the multiplicand M, accumulator A and multiplier Q registers. It produces a registered 2N-bit signed product with a one-cycle valid pulse. The iteration counter is a separate block and is not part of this one.

## Interface
- `N`, default 8: operand width in bits; signed two's complement, N ≥ 2.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset; **synchronous and active-low**.
- `multiplicand_i` input N: signed multiplicand; sampled when `load_b`=1.
- `multiplier_i` input N: signed multiplier; sampled when `load_a`=1.
- `load_b` input 1: capture the multiplicand into M.
- `load_a` input 1: initialise A, Q and Q_1 for a new product.
- `load_add` input 1: accumulate ±M into A.
- `add_sub` input 1: 0 selects A+M; 1 selects A−M. Only meaningful with `load_add`.
- `shift_q` input 1: arithmetic right shift of {A,Q,Q_1}.
- `done` input 1: latch the product.
- `q0` output 1: Q[0]; combinational from the register.
- `q_1` output 1: Q_1; combinational from the register.
- `product_o` output 2N: signed product {A[N-1:0], Q}.
- `product_valid_o` output 1: one-cycle pulse when `product_o` updates.

## Operation
Registers:
- M: N bits.
- A: N+1 bits. The extra sign bit makes M = −2^(N-1) correct, with no overflow case.
- Q: N bits.
- Q_1: 1 bit.
- Product register: 2N bits.
- Valid flag: 1 bit.

Reset:
- While `rst`=0 at a rising edge, every register clears to 0.
- Resulting outputs: `q0`=0, `q_1`=0, `product_o`=0, `product_valid_o`=0.
- Reset overrides all strobes, including reset asserted mid-multiply.

`load_b`:
- M ← `multiplicand_i`.
- Independent of the other strobes; may coincide with `load_a`.

`load_a`:
- A ← 0, Q ← `multiplier_i`, Q_1 ← 0.
- Has priority over `load_add` and `shift_q` in the same cycle; both are ignored.

`load_add` alone:
- A ← A ± sext(M), computed modulo 2^(N+1).

`shift_q` alone:
- {A,Q,Q_1} ← {A[N], A, Q} >> 1, i.e. an arithmetic shift.
- A[N] is replicated; Q_1 ← Q[0]; Q[N-1] ← A[0].

`load_add` and `shift_q` together (fused iteration):
- The add result is shifted in the same cycle.
- A ← (A±M)>>>1.
- Q ← {(A±M)[0], Q[N-1:1]}.
- Q_1 ← Q[0].

`done`:
- Product register ← {A[N-1:0], Q}, using values before this edge's updates.
- `product_valid_o` is 1 for exactly the next cycle.
- `product_o` then holds until the next `done` or reset.
- `done` coinciding with other strobes is legal; the other strobes still execute.

No strobes asserted: all registers hold.

`add_sub` is ignored when `load_add`=0.

## Timing
- All strobes are sampled at the rising edge.
- `q0`/`q_1` reflect the new register values in the same cycle after the edge, with zero added latency. This lets the FSM decide the next iteration combinationally.

Multiply sequence:
- Load: 1 cycle (`load_a`+`load_b`).
- Iterations: N cycles when fused, or up to 2N when add and shift are issued separately.
- Done: 1 cycle.
- `product_valid_o` rises 1 cycle after `done` is sampled.

Minimum latency with fused iterations is N+2 cycles from load to valid.

Back-to-back products:
- `load_a`/`load_b` may be asserted in the same cycle as `done`.
- The product captured is the old {A,Q}.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with all strobes at 1 → `product_o`=0x0000, `product_valid_o`=0, `q0`=0, `q_1`=0. Release; outputs remain 0 with no strobes.
- **3 × −2 (N=8):**
  - Stimulus: `load_a`+`load_b` with M=0x03, Q=0xFE; then 8 fused iterations driven by a Booth reference on `q0`/`q_1`; then `done`.
  - Required: `product_o`=0xFFFA, with `product_valid_o` high for exactly 1 cycle.
- **−128 × −128:**
  - Stimulus: M=0x80, Q=0x80, same sequence.
  - Required: `product_o`=0x4000 (checks the N+1-bit A).
- **Single fused step:**
  - Stimulus: A=0, M=5, Q=0x01, Q_1=0; then `load_add`=`shift_q`=1, `add_sub`=1.
  - Required: A[7:0]=0xFD, Q=0x80, `q0`=0, `q_1`=1.
- **Priority and separate ops:**
  - `load_a` together with `load_add`+`shift_q` → A=0, Q=`multiplier_i`, Q_1=0.
  - Separate `load_add` (A=0, M=3, `add_sub`=0) then `shift_q` → A[7:0]=0x01, Q[N-1]=1.
- **Reset mid-operation and random self-check:**
  - Stimulus: `rst`=0 after the 4th iteration.
  - Required: all registers 0 on the next edge; a new multiply of 7 × 9 then yields 0x003F.
  - Then run 200 random operand pairs against a signed golden product.
